// File: rtl/fnd_pkg.sv
// fnd_pkg -- shared constants for the multiplexed 7-segment display slice.
//   SEG_TABLE  : hex nibble -> {a,b,c,d,e,f,g}, active-low, a is the MSB
//   SEG_BLANK  : all segments off
//   MAX_DIGITS : largest digit count fnd_scan supports
package fnd_pkg;

   localparam int unsigned MAX_DIGITS = 8;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [6:0] SEG_TABLE [16] = '{
      7'b0000001,  // 0
      7'b1001111,  // 1
      7'b0010010,  // 2
      7'b0000110,  // 3
      7'b1001100,  // 4
      7'b0100100,  // 5
      7'b0100000,  // 6
      7'b0001111,  // 7
      7'b0000000,  // 8
      7'b0000100,  // 9
      7'b0001000,  // A
      7'b1100000,  // b
      7'b0110001,  // C
      7'b1000010,  // d
      7'b0110000,  // E
      7'b0111000   // F
   };

endpackage

// File: rtl/fnd_hex_dec.sv
// fnd_hex_dec -- combinational hex nibble to 7-segment decoder.
//   nibble_i : 4-bit hex value
//   seg_o    : {a,b,c,d,e,f,g}, active-low
module fnd_hex_dec
   import fnd_pkg::*;
(
   input  logic [3:0] nibble_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG_TABLE[nibble_i];
   end

endmodule

// File: rtl/fnd_scan.sv
// fnd_scan -- time-multiplexed scanner for DIGITS common-anode 7-segment digits.
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   value      : hex nibbles, nibble i drives digit i (digit 0 least significant)
//   load       : one-cycle strobe capturing value; shown from the next frame
//   dp         : per-digit decimal point request, sampled continuously
//   lzb        : leading-zero blanking enable (digit 0 is never blanked)
//   seg        : segments {a..g}, active-low, registered
//   dp_n       : decimal point, active-low, registered
//   an         : digit enables, active-low one-hot, registered
//   frame_done : one-cycle pulse after the digit index wraps to 0
// Optional feature macro FND_SCAN_BLINK_EN adds input blink and parameter
// BLINK_FRAMES: a phase toggling every BLINK_FRAMES frames blanks the
// selected digits (segments and decimal point) while it is 1.
module fnd_scan
   import fnd_pkg::*;
#(
   parameter int unsigned DIGITS   = 4,
   parameter int unsigned SCAN_DIV = 50000
`ifdef FND_SCAN_BLINK_EN
   ,parameter int unsigned BLINK_FRAMES = 64
`endif
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4*DIGITS-1:0]   value,
   input  logic                  load,
   input  logic [DIGITS-1:0]     dp,
`ifdef FND_SCAN_BLINK_EN
   input  logic [DIGITS-1:0]     blink,
`endif
   input  logic                  lzb,
   output logic [6:0]            seg,
   output logic                  dp_n,
   output logic [DIGITS-1:0]     an,
   output logic                  frame_done
);

   if (DIGITS < 1 || DIGITS > MAX_DIGITS) begin : g_bad_digits
      $error("fnd_scan: DIGITS out of range");
   end

   localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [4*DIGITS-1:0] disp_q, disp_d;
   logic [4*DIGITS-1:0] pend_q, pend_d;
   logic                pend_vld_q, pend_vld_d;
   logic [6:0]          seg_q, seg_d;
   logic                dp_n_q, dp_n_d;
   logic [DIGITS-1:0]   an_q, an_d;
   logic                fd_q, fd_d;

   logic                slot_end;
   logic                frame_end;
   logic [3:0]          nib;
   logic                dp_sel;
   logic                blink_sel;
   logic                zero_above;
   logic                lz_blank;
   logic                blink_blank;
   logic [6:0]          dec_seg;

   assign slot_end  = (cnt_q == CNT_LAST);
   assign frame_end = slot_end && (idx_q == IDX_LAST);

   // Slot counter, digit index and the pending/display double buffer.
   // A load on the boundary cycle goes straight to the display and
   // supersedes anything pending.
   always_comb begin
      cnt_d      = slot_end ? '0 : cnt_q + 1'b1;
      idx_d      = idx_q;
      disp_d     = disp_q;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      if (slot_end) begin
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end
      if (frame_end) begin
         if (load) begin
            disp_d = value;
         end else if (pend_vld_q) begin
            disp_d = pend_q;
         end
         pend_vld_d = 1'b0;
      end else if (load) begin
         pend_d     = value;
         pend_vld_d = 1'b1;
      end
   end

   // Walk digits from the most significant down so zero_above holds
   // "this nibble and every higher one are zero" when the current idx is hit.
   always_comb begin
      nib        = '0;
      dp_sel     = 1'b0;
      blink_sel  = 1'b0;
      zero_above = 1'b1;
      lz_blank   = 1'b0;
      for (int unsigned k = 0; k < DIGITS; k++) begin
         zero_above = zero_above && (disp_q[4*(DIGITS-1-k) +: 4] == 4'h0);
         if (idx_q == IDX_W'(DIGITS-1-k)) begin
            nib      = disp_q[4*(DIGITS-1-k) +: 4];
            dp_sel   = dp[DIGITS-1-k];
            lz_blank = lzb && (k != DIGITS-1) && zero_above;
`ifdef FND_SCAN_BLINK_EN
            blink_sel = blink[DIGITS-1-k];
`endif
         end
      end
   end

   fnd_hex_dec u_dec (
      .nibble_i (nib),
      .seg_o    (dec_seg)
   );

`ifdef FND_SCAN_BLINK_EN
   localparam int unsigned BF_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [BF_W-1:0] BF_LAST = BF_W'(BLINK_FRAMES - 1);

   logic [BF_W-1:0] bcnt_q;
   logic            phase_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bcnt_q  <= '0;
         phase_q <= 1'b0;
      end else if (frame_end) begin
         if (bcnt_q == BF_LAST) begin
            bcnt_q  <= '0;
            phase_q <= ~phase_q;
         end else begin
            bcnt_q <= bcnt_q + 1'b1;
         end
      end
   end

   assign blink_blank = phase_q && blink_sel;
`else
   assign blink_blank = 1'b0 & blink_sel;
`endif

   // Output stage: first clock of every slot keeps all anodes off so the
   // segment change never ghosts onto the previous digit.
   always_comb begin
      seg_d  = (lz_blank || blink_blank) ? SEG_BLANK : dec_seg;
      dp_n_d = blink_blank ? 1'b1 : ~dp_sel;
      an_d   = (cnt_q == '0) ? '1 : ~(DIGITS'(1) << idx_q);
      fd_d   = frame_end;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q      <= '0;
         idx_q      <= '0;
         disp_q     <= '0;
         pend_q     <= '0;
         pend_vld_q <= 1'b0;
         seg_q      <= SEG_BLANK;
         dp_n_q     <= 1'b1;
         an_q       <= '1;
         fd_q       <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         disp_q     <= disp_d;
         pend_q     <= pend_d;
         pend_vld_q <= pend_vld_d;
         seg_q      <= seg_d;
         dp_n_q     <= dp_n_d;
         an_q       <= an_d;
         fd_q       <= fd_d;
      end
   end

   assign seg        = seg_q;
   assign dp_n       = dp_n_q;
   assign an         = an_q;
   assign frame_done = fd_q;

endmodule

// File: tb/tb_fnd_scan.sv
// tb_fnd_scan -- self-checking bench for fnd_scan (DIGITS=4, SCAN_DIV=4).
// A reference model derives the expected outputs from the cycle count since
// reset (slot/digit position by division) and a displayed/pending value pair.
module tb_fnd_scan;

   localparam int D = 4;
   localparam int S = 4;
   localparam int F = D * S;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] value;
   logic        load;
   logic [3:0]  dp;
   logic        lzb;
   logic [6:0]  seg;
   logic        dp_n;
   logic [3:0]  an;
   logic        frame_done;

   fnd_scan #(.DIGITS(D), .SCAN_DIV(S)) dut (
      .clk        (clk),
      .rst        (rst),
      .value      (value),
      .load       (load),
      .dp         (dp),
      .lzb        (lzb),
      .seg        (seg),
      .dp_n       (dp_n),
      .an         (an),
      .frame_done (frame_done)
   );

   initial forever #5 clk = ~clk;

   int          tests = 0;
   int          fails = 0;
   int          k;              // clock edges since reset release
   logic [15:0] m_disp;
   logic [15:0] m_pend;
   bit          m_pflag;
   logic [6:0]  seen [4];       // last lit segment pattern seen per digit

   typedef struct {
      logic [15:0] value;
      logic        lzb;
      logic [27:0] exp;         // {digit3, digit2, digit1, digit0}
   } vec_t;

   vec_t vecs [8];

   function automatic logic [6:0] hexseg(input logic [3:0] n);
      case (n)
         4'h0: return 7'b0000001;
         4'h1: return 7'b1001111;
         4'h2: return 7'b0010010;
         4'h3: return 7'b0000110;
         4'h4: return 7'b1001100;
         4'h5: return 7'b0100100;
         4'h6: return 7'b0100000;
         4'h7: return 7'b0001111;
         4'h8: return 7'b0000000;
         4'h9: return 7'b0000100;
         4'hA: return 7'b0001000;
         4'hB: return 7'b1100000;
         4'hC: return 7'b0110001;
         4'hD: return 7'b1000010;
         4'hE: return 7'b0110000;
         default: return 7'b0111000;
      endcase
   endfunction

   function automatic logic [6:0] model_seg(input int idx);
      logic [15:0] up;
      up = m_disp >> (4 * idx);
      if (lzb && idx > 0 && up == 16'h0) return 7'b1111111;
      return hexseg(up[3:0]);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s (edge %0d): got %0h expected %0h", nm, k, act, exp);
      end
   endtask

   task automatic clear_seen();
      for (int i = 0; i < 4; i++) seen[i] = 7'bx;
   endtask

   // One clock: expectations are fixed from the pre-edge model state, then
   // the model applies the load/boundary rules for that edge.
   task automatic tick(input bit ld, input logic [15:0] v);
      int         cnt, idx;
      logic [3:0] an_e;
      logic [6:0] seg_e;
      logic       dpn_e;
      bit         bnd;
      load  = ld;
      value = v;
      cnt   = k % S;
      idx   = (k / S) % D;
      an_e  = (cnt == 0) ? 4'hF : ~(4'b0001 << idx);
      seg_e = model_seg(idx);
      dpn_e = ~dp[idx];
      bnd   = ((k + 1) % F) == 0;
      @(posedge clk);
      #1;
      chk("an", 32'(an), 32'(an_e));
      chk("seg", 32'(seg), 32'(seg_e));
      chk("dp_n", 32'(dp_n), 32'(dpn_e));
      chk("frame_done", 32'(frame_done), 32'(bnd));
      for (int i = 0; i < 4; i++) begin
         if (an == ~(4'b0001 << i)) seen[i] = seg;
      end
      if (bnd) begin
         if (ld) m_disp = v;
         else if (m_pflag) m_disp = m_pend;
         m_pflag = 1'b0;
      end else if (ld) begin
         m_pend  = v;
         m_pflag = 1'b1;
      end
      k++;
      load = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, value);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      chk("rst_an", 32'(an), 32'hF);
      chk("rst_seg", 32'(seg), 32'h7F);
      chk("rst_dp_n", 32'(dp_n), 32'h1);
      chk("rst_frame_done", 32'(frame_done), 32'h0);
      k       = 0;
      m_disp  = '0;
      m_pend  = '0;
      m_pflag = 1'b0;
      load    = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic chk_digits(input string nm, input logic [27:0] e);
      logic [27:0] ev;
      ev = e;
      for (int i = 0; i < 4; i++) chk(nm, 32'(seen[i]), 32'(ev[7*i +: 7]));
   endtask

   logic [3:0] an_tab [16];
   logic [3:0] rec_an [16];
   bit         rec_fd [16];
   int         fd_cnt;

   initial begin
      vecs[0] = '{16'h12AF, 1'b0, {7'b1001111, 7'b0010010, 7'b0001000, 7'b0111000}};
      vecs[1] = '{16'h0040, 1'b1, {7'b1111111, 7'b1111111, 7'b1001100, 7'b0000001}};
      vecs[2] = '{16'h0000, 1'b1, {7'b1111111, 7'b1111111, 7'b1111111, 7'b0000001}};
      vecs[3] = '{16'h0000, 1'b0, {7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001}};
      vecs[4] = '{16'h0305, 1'b1, {7'b1111111, 7'b0000110, 7'b0000001, 7'b0100100}};
      vecs[5] = '{16'hBCDE, 1'b0, {7'b1100000, 7'b0110001, 7'b1000010, 7'b0110000}};
      vecs[6] = '{16'h8000, 1'b1, {7'b0000000, 7'b0000001, 7'b0000001, 7'b0000001}};
      vecs[7] = '{16'h3679, 1'b0, {7'b0000110, 7'b0100000, 7'b0001111, 7'b0000100}};
      an_tab  = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD,
                  4'hF, 4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7};

      rst   = 1'b0;
      load  = 1'b0;
      value = '0;
      dp    = '0;
      lzb   = 1'b0;
      k     = 0;
      clear_seen();
      #2;
      do_reset();

      // Scan order and frame pulse straight out of reset.
      fd_cnt = 0;
      for (int j = 0; j < 16; j++) begin
         tick(1'b0, 16'h0);
         rec_an[j] = an;
         rec_fd[j] = frame_done;
         if (frame_done) fd_cnt++;
      end
      for (int j = 0; j < 16; j++) chk("an_seq", 32'(rec_an[j]), 32'(an_tab[j]));
      chk("fd_once", 32'(fd_cnt), 32'd1);
      chk("fd_pos", 32'(rec_fd[15]), 32'd1);

      // Static display patterns: load mid-frame, then observe a whole frame.
      for (int v = 0; v < 8; v++) begin
         lzb = vecs[v].lzb;
         dp  = 4'($urandom);
         idle(5);
         tick(1'b1, vecs[v].value);
         idle(2 * F);
         clear_seen();
         idle(F);
         chk_digits("vec_digits", vecs[v].exp);
      end

      // Two loads in one frame, then a load exactly on the boundary cycle.
      lzb = 1'b0;
      dp  = 4'h0;
      while (k % F != 5) tick(1'b0, value);
      tick(1'b1, 16'h0005);
      idle(3);
      tick(1'b1, 16'h0007);
      for (int g = 0; g < F && ((k + 1) % F) != 0; g++) tick(1'b0, value);
      chk("bnd_align", 32'((k + 1) % F), 32'd0);
      tick(1'b1, 16'h0009);
      clear_seen();
      idle(F);
      chk_digits("bnd_load", {7'b0000001, 7'b0000001, 7'b0000001, 7'b0000100});
      idle(F);
      clear_seen();
      idle(F);
      chk_digits("no_stale_pend", {7'b0000001, 7'b0000001, 7'b0000001, 7'b0000100});

      // Decimal point on digit 2, pending load, then reset mid-slot of digit 2.
      dp = 4'b0100;
      while (k % F != 2) tick(1'b0, value);
      tick(1'b1, 16'hABCD);
      while (k % F != 2 * S + 2) tick(1'b0, value);
      chk("dp_slot2", 32'(dp_n), 32'd0);
      do_reset();
      dp = 4'h0;
      clear_seen();
      idle(3 * F);
      chk_digits("pend_dropped", {7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001});

      // Randomised traffic, occasionally resetting.
      for (int r = 0; r < 800; r++) begin
         dp = 4'($urandom);
         if ($urandom_range(0, 31) == 0) lzb = ~lzb;
         if ($urandom_range(0, 299) == 0) do_reset();
         tick($urandom_range(0, 7) == 0, 16'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/fnd_scan.md
FND_SCAN -- requirements
Module: fnd_scan

Interface
REQ-001 The block SHALL have parameter DIGITS, default 4, giving the number of multiplexed 7-segment digits (range 1..8).
REQ-002 The block SHALL have parameter SCAN_DIV, default 50000, giving clocks per digit slot (minimum 2).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port value, input, 4*DIGITS bits: hex nibbles, with nibble i driving digit i and digit 0 as the least significant.
REQ-006 The block SHALL have port load, input, 1 bit: a one-cycle strobe that captures value.
REQ-007 The block SHALL have port dp, input, DIGITS bits: decimal-point request per digit, sampled continuously.
REQ-008 The block SHALL have port lzb, input, 1 bit: leading-zero blanking enable.
REQ-009 The block SHALL have port seg, output, 7 bits: segments {a,b,c,d,e,f,g} with a as the MSB, active-low.
REQ-010 The block SHALL have port dp_n, output, 1 bit: decimal point, active-low.
REQ-011 The block SHALL have port an, output, DIGITS bits: digit enables, active-low, one-hot-low.
REQ-012 The block SHALL have port frame_done, output, 1 bit: a one-cycle pulse at each frame wrap.

Function
REQ-013 Slot counter cnt SHALL count 0..SCAN_DIV-1 and wrap; on the wrap, digit index idx SHALL advance, going DIGITS-1 -> 0.
REQ-014 frame_done SHALL pulse for exactly one cycle, registered, in the cycle after idx wraps DIGITS-1 -> 0.
REQ-015 The output registers seg, dp_n and an SHALL reflect the current idx with one clock of latency.
REQ-016 an SHALL be all ones for the first clock of every digit slot (anti-ghosting gap); for the remaining SCAN_DIV-1 clocks it SHALL drive bit idx low and all other bits high.
REQ-017 Segment encoding SHALL be 0:0000001 1:1001111 2:0010010 3:0000110 4:1001100 5:0100100 6:0100000 7:0001111 8:0000000 9:0000100 A:0001000 b:1100000 C:0110001 d:1000010 E:0110000 F:0111000.
REQ-018 load SHALL copy value into a pending register and set a pending flag.
REQ-019 The display register SHALL update only at a frame boundary (idx wrap to 0), and only if the pending flag is set; the pending flag SHALL then be cleared.
REQ-020 If load coincides with a frame boundary, the display register SHALL take value directly in that cycle and the pending flag SHALL remain clear.
REQ-021 Back-to-back loads within one frame SHALL leave the last load's value displayed; earlier loads are discarded.
REQ-022 With lzb=1, every digit i>0 whose nibble and all higher nibbles are 0 SHALL output seg=1111111, and digit 0 SHALL never be blanked.
REQ-023 dp_n SHALL equal ~dp[idx] regardless of blanking.

Reset
REQ-024 Reset SHALL set cnt=0, idx=0, display=0, pending=0 and flag clear, seg=1111111, dp_n=1, an all ones, frame_done=0.
REQ-025 Reset asserted mid-frame SHALL discard any pending load.
REQ-026 After reset release, scanning SHALL restart at digit 0 with the anti-ghosting gap.

Configuration
REQ-027 Macro FND_SCAN_BLINK_EN, when defined, SHALL add input blink[DIGITS-1:0] and parameter BLINK_FRAMES, default 64.
REQ-028 With FND_SCAN_BLINK_EN defined, a blink phase SHALL toggle every BLINK_FRAMES frames; while the phase is 1, digits with blink[i]=1 SHALL output seg=1111111 and dp_n=1. Reset SHALL set the phase to 0.
REQ-029 With FND_SCAN_BLINK_EN undefined, the blink port, BLINK_FRAMES parameter and phase logic SHALL be absent, and behaviour SHALL be exactly as REQ-013..REQ-023.

Structure
REQ-030 Shared package fnd_pkg SHALL hold the 16-entry segment table, SEG_BLANK=7'b1111111, and the digit-count limit constant.
REQ-031 One combinational sub-module fnd_hex_dec (nibble -> seg, using fnd_pkg) SHALL be instantiated once on the selected nibble; scanning and state SHALL stay in fnd_scan.

Verification (DIGITS=4, SCAN_DIV=4)
REQ-032 Reset release, then run 16 clocks -> an sequence SHALL be 1111,1110,1110,1110,1111,1101,..., with frame_done pulsed once after digit 3.
REQ-033 load with value=16'h12AF mid-frame -> the old value SHALL persist until the frame boundary; from the next frame, digits 3..0 SHALL show 1001111,0010010,0001000,0111000.
REQ-034 load 16'h0005 then 16'h0007 in the same frame, with load also driven on the boundary cycle carrying 16'h0009 -> the display SHALL show 9, and the pending flag SHALL be clear.
REQ-035 lzb=1 with value=16'h0040 -> digits 3 and 2 SHALL be blanked, digit 1 SHALL show 1001100 and digit 0 SHALL show 0000001. value=16'h0000 -> only digit 0 SHALL be lit, showing 0.
REQ-036 dp=4'b0100, then rst asserted mid-slot at idx=2 -> dp_n SHALL be 0 only in the digit-2 slot before reset; rst SHALL immediately force an=1111, seg=1111111, dp_n=1.
REQ-037 With FND_SCAN_BLINK_EN, BLINK_FRAMES=2 and blink=4'b0001 -> digit 0 SHALL be lit for 2 frames, blank for 2 frames, and repeat, while the other digits stay steady.
